// File: rtl/led_chaser_m.sv
// rtl/led_chaser_m.sv - LED pattern chaser advanced by prescaler-bit rising edges
//
// Purpose: turns each rising edge of presc_in[TICK_BIT] into a one-cycle tick
// and steps an LED pattern (off / blink / rotate / bounce) on every tick.
// Optional feature macro: LED_CHASER_PWM_EN (registered PWM dimming of led).
//
// Ports:
//   clk       system clock (also clocks the prescaler)
//   rst       asynchronous, active-high reset
//   presc_in  prescaler output bus, synchronous to clk
//   mode      pattern select: 0 OFF, 1 BLINK, 2 ROTATE, 3 BOUNCE
//   enable    1 = pattern advances on ticks, 0 = pattern frozen
//   tick      one-cycle pulse per rising edge of presc_in[TICK_BIT]
//   led       LED drive, active-high
module led_chaser_m #(
  parameter int PRESC_WIDTH = 4,
  parameter int TICK_BIT    = PRESC_WIDTH - 1,
  parameter int LED_NUM     = 4,
  parameter int PWM_DUTY    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PRESC_WIDTH-1:0] presc_in,
  input  logic [1:0]             mode,
  input  logic                   enable,
  output logic                   tick,
  output logic [LED_NUM-1:0]     led
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  localparam logic [LED_NUM-1:0] PAT_ONE = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] PAT_MSB = {1'b1, {(LED_NUM-1){1'b0}}};

  logic               prev_q;
  logic               rise;
  mode_t              mode_q;
  logic [LED_NUM-1:0] pat;
  logic               dir;
  logic [LED_NUM-1:0] pat_up;
  logic [LED_NUM-1:0] pat_dn;
  logic [LED_NUM-1:0] pat_rot;

  // Only the tick bit (and the two PWM count bits, when enabled) are consumed;
  // the rest of the shared prescaler bus is deliberately ignored.
  logic unused_presc;
  assign unused_presc = ^presc_in;

  assign rise    = presc_in[TICK_BIT] & ~prev_q;
  assign pat_up  = pat << 1;
  assign pat_dn  = pat >> 1;
  assign pat_rot = {pat[LED_NUM-2:0], pat[LED_NUM-1]};

`ifdef LED_CHASER_PWM_EN
  localparam logic [2:0] DUTY = 3'(PWM_DUTY);
  logic pwm_on;
  assign pwm_on = ({1'b0, presc_in[1:0]} < DUTY);
`else
  logic [31:0] unused_duty;
  assign unused_duty = PWM_DUTY;
  assign led = pat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      tick   <= 1'b0;
      mode_q <= MODE_OFF;
      pat    <= '0;
      dir    <= 1'b0;
`ifdef LED_CHASER_PWM_EN
      led    <= '0;
`endif
    end else begin
      prev_q <= presc_in[TICK_BIT];
      tick   <= rise;
      mode_q <= mode_t'(mode);

      if (mode != mode_q) begin
        // Reload on any mode change; a tick landing in this cycle is dropped.
        dir <= 1'b0;
        if (mode == MODE_ROTATE || mode == MODE_BOUNCE) pat <= PAT_ONE;
        else                                            pat <= '0;
      end else if (tick && enable) begin
        case (mode_q)
          MODE_OFF:    pat <= '0;
          MODE_BLINK:  pat <= ~pat;
          MODE_ROTATE: pat <= pat_rot;
          MODE_BOUNCE: begin
            // Turn around as soon as an endpoint is reached so each end
            // is lit for exactly one tick.
            if (!dir) begin
              pat <= pat_up;
              if (pat_up == PAT_MSB) dir <= 1'b1;
            end else begin
              pat <= pat_dn;
              if (pat_dn == PAT_ONE) dir <= 1'b0;
            end
          end
          default:     pat <= '0;
        endcase
      end

`ifdef LED_CHASER_PWM_EN
      led <= pat & {LED_NUM{pwm_on}};
`endif
    end
  end

endmodule
